// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg : shared sample width, midscale code and feeder states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pdm_pkg;

  localparam int PDM_NBITS = 11;
  localparam logic [PDM_NBITS-1:0] MID = {1'b1, {(PDM_NBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/pdm_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// pdm_sample_feeder_if : AXI4-Stream sample bus into the feeder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pdm_sample_feeder_if
  import pdm_pkg::*;
#(
  parameter int NBITS = PDM_NBITS
);
  logic [NBITS-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/pdm_feeder_fifo.sv
// ---------------------------------------------------------------------------
// pdm_feeder_fifo : sync FIFO, registered full/empty/count, FWFT read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_feeder_fifo #(
  parameter int WIDTH = 11,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_wr;
  logic             w_rd;

  // Both gates use registered flags: a full FIFO refuses a write even when it pops.
  assign w_wr = wr_en && !r_full;
  assign w_rd = rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
endmodule

`default_nettype wire

// File: rtl/pdm_sample_feeder.sv
// ---------------------------------------------------------------------------
// pdm_sample_feeder : paces FIFO'd samples to the PDM at one per period+1 clks.
// Option macro PDM_FEEDER_UNDERFLOW_CNT_EN adds underflow_count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_sample_feeder
  import pdm_pkg::*;
#(
  parameter int NBITS     = PDM_NBITS,
  parameter int FIFO_AW   = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pdm_sample_feeder_if.slave   s_axis,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic [NBITS-1:0]     data_out,
  output logic                 sample_tick,
  output logic                 underflow,
  output logic [FIFO_AW:0]     fifo_count
`ifdef PDM_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]          underflow_count
`endif
);
  localparam logic [NBITS-1:0] C_MID = {1'b1, {(NBITS-1){1'b0}}};

  feeder_state_t        r_state;
  feeder_state_t        w_state_nxt;
  logic [DIV_WIDTH-1:0] r_hold;
  logic [NBITS-1:0]     r_data;
  logic                 r_tick;
  logic                 r_underflow;
  logic                 w_pop;
  logic                 w_underflow;
  logic                 w_full;
  logic                 w_empty;
  logic [NBITS-1:0]     w_head;

  assign s_axis.tready = !w_full && !rst;

  pdm_feeder_fifo #(
    .WIDTH (NBITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_axis.tvalid),
    .wr_data (s_axis.tdata),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_underflow = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (r_hold == '0) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_underflow = 1'b1;
              w_state_nxt = STARVED;
            end
          end
        end
        STARVED: begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Pop decided this cycle; the popped word and its tick appear next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_data      <= C_MID;
      r_tick      <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick      <= w_pop;
      r_underflow <= w_underflow;
      if (w_pop) begin
        r_hold <= period;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
      if (!enable) begin
        r_data <= C_MID;
      end else if (w_pop) begin
        r_data <= w_head;
      end
    end
  end

  assign data_out    = r_data;
  assign sample_tick = r_tick;
  assign underflow   = r_underflow;

`ifdef PDM_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0] r_uf_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uf_count <= '0;
    end else if (w_underflow && (r_uf_count != 16'hFFFF)) begin
      r_uf_count <= r_uf_count + 1'b1;
    end
  end

  assign underflow_count = r_uf_count;
`endif
endmodule

`default_nettype wire

// File: tb/tb_pdm_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_pdm_sample_feeder : randomized bench against a queue-based reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pdm_sample_feeder;
  import pdm_pkg::*;

  localparam int NB    = PDM_NBITS;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;
  localparam int M_IDLE = 0, M_RUN = 1, M_STARVED = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] period = '0;
  logic [NB-1:0] data_out;
  logic          sample_tick;
  logic          underflow;
  logic [AW:0]   fifo_count;
`ifdef PDM_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_count;
`endif

  pdm_sample_feeder_if #(.NBITS(NB)) axis ();

  always #5 clk = ~clk;

  pdm_sample_feeder #(
    .NBITS     (NB),
    .FIFO_AW   (AW),
    .DIV_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (axis.slave),
    .enable      (enable),
    .period      (period),
    .data_out    (data_out),
    .sample_tick (sample_tick),
    .underflow   (underflow),
    .fifo_count  (fifo_count)
`ifdef PDM_FEEDER_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a queue for the buffer plus the hold time left on the current sample.
  int unsigned q[$];
  int          mode = M_IDLE;
  int unsigned hold_left = 0;
  int unsigned m_out = MID;
  bit          m_tick = 0;
  bit          m_uf = 0;
  int unsigned m_ufcnt = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin : model
    bit was_full;
    bit do_pop;
    bit do_uf;
    was_full = (q.size() == DEPTH);
    do_pop   = 0;
    do_uf    = 0;
    if (rst) begin
      q.delete();
      mode = M_IDLE; hold_left = 0; m_out = MID; m_tick = 0; m_uf = 0; m_ufcnt = 0;
    end else begin
      if (!enable) begin
        mode = M_IDLE;
      end else if (q.size() != 0 && (mode != M_RUN || hold_left == 0)) begin
        do_pop = 1;
        mode   = M_RUN;
      end else if (mode == M_RUN && hold_left == 0) begin
        do_uf = 1;
        mode  = M_STARVED;
      end
      m_tick = do_pop;
      m_uf   = do_uf;
      if (do_uf && m_ufcnt != 16'hFFFF) m_ufcnt++;
      if (!enable) m_out = MID;
      else if (do_pop) m_out = q[0];
      if (do_pop) begin
        void'(q.pop_front());
        hold_left = period;
      end else if (hold_left > 0) begin
        hold_left--;
      end
      if (axis.tvalid && !was_full) q.push_back(axis.tdata);
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("data_out", data_out, m_out);
      check_eq("sample_tick", sample_tick, m_tick);
      check_eq("underflow", underflow, m_uf);
      check_eq("fifo_count", fifo_count, q.size());
      check_eq("tready", axis.tready, (!rst && q.size() < DEPTH) ? 1 : 0);
`ifdef PDM_FEEDER_UNDERFLOW_CNT_EN
      check_eq("underflow_count", underflow_count, m_ufcnt);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int unsigned v);
    int guard;
    guard = 0;
    axis.tdata  = NB'(v);
    axis.tvalid = 1'b1;
    while (!axis.tready && guard < 200) begin
      cyc(1);
      guard++;
    end
    if (guard >= 200) check_eq("push_timeout", guard, 0);
    cyc(1);
    axis.tvalid = 1'b0;
  endtask

  initial begin
    axis.tdata  = '0;
    axis.tvalid = 1'b0;
    rst = 1'b1;
    cyc(2);
    check_eq("reset_mid", data_out, 1024);
    check_eq("reset_count", fifo_count, 0);
    rst = 1'b0;

    // Pacing: three samples, each held period+1 clocks, then one underflow.
    period = 3;
    enable = 1'b1;
    push(100);
    push(200);
    push(300);
    cyc(20);
    check_eq("hold_last", data_out, 300);

    // Fill while disabled, then drain in order.
    enable = 1'b0;
    axis.tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      axis.tdata = NB'($urandom);
      cyc(1);
    end
    check_eq("full_count", fifo_count, DEPTH);
    check_eq("full_tready", axis.tready, 0);
    axis.tvalid = 1'b0;
    period = DW'($urandom_range(0, 3));
    enable = 1'b1;
    cyc(80);

    // Full FIFO, period 0, source always valid: one sample per clock.
    enable = 1'b0;
    axis.tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      axis.tdata = NB'($urandom);
      cyc(1);
    end
    period = 0;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      axis.tdata = NB'($urandom);
      cyc(1);
    end
    axis.tvalid = 1'b0;
    cyc(25);

    // Starve, then recover with a single write.
    period = 2;
    push(7);
    cyc(10);
    axis.tdata  = NB'(500);
    axis.tvalid = 1'b1;
    cyc(1);
    axis.tvalid = 1'b0;
    cyc(1);
    check_eq("recover_500", data_out, 500);

    // Drop enable mid-hold, then reset mid-hold.
    period = 6;
    push(11); push(22); push(33);
    cyc(3);
    enable = 1'b0;
    cyc(1);
    check_eq("disable_mid", data_out, MID);
    enable = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    check_eq("rst_mid_data", data_out, MID);
    check_eq("rst_mid_count", fifo_count, 0);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      axis.tdata  = NB'($urandom);
      axis.tvalid = ($urandom_range(0, 99) < 45);
      enable      = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 19) == 0) period = DW'($urandom_range(0, 5));
      rst         = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    axis.tvalid = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
